serial_subtractor_16bit: RTL
============================

# serial_subtractor_16bit

Bit-serial 16-bit two's-complement subtractor: the inverse of the team's combinational 16-bit adder datapath. It accepts an operand pair on a start pulse and computes `a - b - borrow_in` one bit per clock, LSB first. When finished it presents `diff`, `borrow_out` and signed `overflow` with a one-cycle `done` pulse. It sits beside the adder in the arithmetic lab datapath, trading area for latency, and its results are cross-checked against the adder.

## Interface
Parameters:
- WIDTH, 16, operand and result width. Only 16 is supported; the parameter exists for the package constant.

Ports:
- clk  in  1  rising-edge clock
- n_rst  in  1  synchronous, active-low reset
- start  in  1  request; sampled on each rising edge
- a  in  16  minuend
- b  in  16  subtrahend
- borrow_in  in  1  incoming borrow
- busy  out  1  high while bits are being processed
- done  out  1  one-cycle pulse when results update
- diff  out  16  registered result
- borrow_out  out  1  high when unsigned a < b + borrow_in
- overflow  out  1  signed overflow of a - b - borrow_in

## Operation
- Reset and clock: one clock; reset is synchronous and active-low (`n_rst` sampled on `clk` rising edge).
- Reset values: state IDLE, busy=0, done=0, diff=16'h0000, borrow_out=0, overflow=0, bit counter=0.
- Arithmetic: implemented as a + ~b + carry.
  - Initial carry = !borrow_in.
  - At each bit i: sum_i = a_i ^ ~b_i ^ c; c' = majority(a_i, ~b_i, c).
  - borrow_out = !final carry.
  - overflow = (a[15] != b[15]) && (diff[15] != a[15]).
- States:
  - IDLE: start=1 latches a, b and the initial carry into shift/carry registers, clears the counter, and goes to BUSY.
  - BUSY: processes bit `count` each edge and increments the counter. After bit 15 it goes to DONE.
  - DONE: done=1 for this one cycle. Output registers update on the edge entering DONE. With start=1 it goes straight to BUSY, latching new operands; otherwise it goes to IDLE.
- busy=1 exactly in BUSY.
- start is ignored in BUSY; a/b changes during BUSY have no effect.
- Outputs hold their last value from the DONE update until the next DONE update. Partial results are never visible on `diff`.
- Reset mid-operation: abort, return to reset values, no done pulse.

## Timing
- Acceptance edge N: start=1 in IDLE or DONE.
- Edges N+1 through N+16 process bits 0 through 15.
- busy is high after edge N through edge N+15; it falls at edge N+16.
- done, diff, borrow_out and overflow update at edge N+16; done falls at edge N+17.
- Back-to-back: start held high in DONE gives a 17-cycle issue interval.
- No combinational path from inputs to outputs.

## Structure
- Package `serial_sub_pkg`:
  - `localparam WIDTH = 16`
  - `localparam CNT_BITS = 4`
  - `typedef enum logic [1:0] {IDLE, BUSY, DONE} sub_state_t`
- Sub-module `serial_bit_sub`: combinational one-bit full subtract cell (a_i, b_i, carry_in → diff_i, carry_out). It is instantiated once inside the top, with the FSM, counter and shift registers.

## Test plan
- Basic subtract: a=16'h0005, b=16'h0003, borrow_in=0, start at edge N → diff=16'h0002, borrow_out=0, overflow=0; done high only after edge N+16; busy high for 16 cycles.
- Unsigned wrap: a=16'h0000, b=16'h0001 → diff=16'hFFFF, borrow_out=1, overflow=0.
- Negative overflow: a=16'h8000, b=16'h0001 → diff=16'h7FFF, overflow=1, borrow_out=0.
- Positive overflow: a=16'h7FFF, b=16'hFFFF → diff=16'h8000, overflow=1, borrow_out=1.
- Borrow input: a=16'h0010, b=16'h0010, borrow_in=1 → diff=16'hFFFF, borrow_out=1, overflow=0.
- Handshake and reset:
  - start and changed a/b pulsed at bit 5 → ignored; first result unchanged.
  - start held in DONE → second result after 17 cycles.
  - n_rst=0 at bit 8 → next edge: IDLE, busy=0, diff=16'h0000, no done pulse.

Source files
------------

// File: rtl/serial_subtractor_16bit_pkg.sv
// rtl/serial_subtractor_16bit_pkg.sv - shared constants and state type for the serial subtractor
// Purpose: operand width, bit-counter width and the FSM state encoding.
// Ports: none (package).
package serial_sub_pkg;
  localparam int WIDTH    = 16;
  localparam int CNT_BITS = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} sub_state_t;
endpackage

// File: rtl/serial_subtractor_16bit_if.sv
// rtl/serial_subtractor_16bit_if.sv - request/result bundle of the serial subtractor
// Purpose: groups the operand request and the result signals.
// Ports (signals): start, a, b, borrow_in (requester -> subtractor);
//                  busy, done, diff, borrow_out, overflow (subtractor -> requester).
// Modports: master = requester, slave = subtractor.
interface serial_subtractor_16bit_if;
  import serial_sub_pkg::*;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, borrow_out, overflow
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, borrow_out, overflow
  );
endinterface

// File: rtl/serial_subtractor_16bit_bit_sub.sv
// rtl/serial_subtractor_16bit_bit_sub.sv - one-bit subtract cell (a + ~b + carry)
// Purpose: combinational full-subtract slice used once per clock by the serial datapath.
// Ports: a_i, b_i, carry_in (in); diff_i, carry_out (out). carry is the inverted borrow.
module serial_bit_sub (
  input  logic a_i,
  input  logic b_i,
  input  logic carry_in,
  output logic diff_i,
  output logic carry_out
);
  logic nb;

  assign nb        = ~b_i;
  assign diff_i    = a_i ^ nb ^ carry_in;
  assign carry_out = (a_i & nb) | (a_i & carry_in) | (nb & carry_in);
endmodule

// File: rtl/serial_subtractor_16bit.sv
// rtl/serial_subtractor_16bit.sv - bit-serial 16-bit two's-complement subtractor
// Purpose: computes a - b - borrow_in one bit per clock, LSB first, and publishes
//          diff/borrow_out/overflow with a one-cycle done pulse.
// Ports: clk (rising-edge clock), n_rst (synchronous active-low reset),
//        sub_if (slave modport: start/a/b/borrow_in in; busy/done/diff/borrow_out/overflow out).
module serial_subtractor_16bit
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = serial_sub_pkg::WIDTH
) (
  input  logic                      clk,
  input  logic                      n_rst,
  serial_subtractor_16bit_if.slave  sub_if
);

  sub_state_t          state_q, state_d;
  logic                load;
  logic                last_bit;

  logic [WIDTH-1:0]    a_sh, b_sh;
  logic                carry_q;
  logic [CNT_BITS-1:0] count_q;
  // Holds the low WIDTH-1 result bits; the final bit is merged in on the last edge
  // so diff never shows a partial value.
  logic [WIDTH-2:0]    acc_q;
  logic                a_msb_q, b_msb_q;

  logic [WIDTH-1:0]    diff_q;
  logic                borrow_q;
  logic                ovf_q;

  logic                sum_bit;
  logic                carry_next;

  serial_bit_sub u_bit_sub (
    .a_i       (a_sh[0]),
    .b_i       (b_sh[0]),
    .carry_in  (carry_q),
    .diff_i    (sum_bit),
    .carry_out (carry_next)
  );

  assign last_bit = (state_q == BUSY) && (count_q == CNT_BITS'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sub_if.start) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        if (sub_if.start) begin
          load    = 1'b1;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      acc_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        a_sh    <= sub_if.a;
        b_sh    <= sub_if.b;
        carry_q <= ~sub_if.borrow_in;
        count_q <= '0;
        // Operand sign bits are kept aside because the shifters consume them.
        a_msb_q <= sub_if.a[WIDTH-1];
        b_msb_q <= sub_if.b[WIDTH-1];
      end else if (state_q == BUSY) begin
        a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
        b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
        carry_q <= carry_next;
        acc_q   <= {sum_bit, acc_q[WIDTH-2:1]};
        count_q <= count_q + 1'b1;
        if (last_bit) begin
          diff_q   <= {sum_bit, acc_q};
          borrow_q <= ~carry_next;
          ovf_q    <= (a_msb_q != b_msb_q) && (sum_bit != a_msb_q);
        end
      end
    end
  end

  assign sub_if.busy       = (state_q == BUSY);
  assign sub_if.done       = (state_q == DONE);
  assign sub_if.diff       = diff_q;
  assign sub_if.borrow_out = borrow_q;
  assign sub_if.overflow   = ovf_q;

endmodule
